seq_alu: RTL and testbench

Parametrised, multi-cycle integer execution unit for the MIPS datapath. It replaces the purely combinational ALU. It adds signed and unsigned compare, XOR/NOR, signed-overflow detection, and iterative MULT/MULTU/DIV/DIVU writing architectural HI/LO registers. Every operation uses a start/done handshake so the control unit can stall on long operations.

---
 rtl/seq_alu_pkg.sv | 47 ++++
 rtl/seq_alu_mdu_iter.sv | 75 +++++++
 rtl/seq_alu.sv | 182 ++++++++++++++++++
 tb/tb_seq_alu.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// alu_pkg: shared types and helpers for the seq_alu execution unit.
//   alu_op_t    - 4-bit opcode carried on seq_alu.op
//   mdu_state_t - multiply/divide sequencer state
//   is_muldiv() - opcode needs the iterative multiply/divide unit
//   is_signed() - opcode treats its operands as two's complement (MULT, DIV)
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MFLO  = 4'd9,
    OP_MULT  = 4'd10,
    OP_MULTU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  function automatic logic is_muldiv(input alu_op_t op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(input alu_op_t op);
    case (op)
      OP_MULT, OP_DIV: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_alu_mdu_iter.sv
// mdu_iter: unsigned iterative multiply / restoring divide datapath.
//   load      - capture a_abs/b_abs, select mul or div, arm counter with WIDTH
//   is_div    - 1: divide a_abs by b_abs, 0: multiply a_abs by b_abs
//   step_done - high during the cycle in which the final step is taken
//   hi_raw    - product high half / unsigned remainder
//   lo_raw    - product low half  / unsigned quotient
// One step is taken on every edge while the counter is non-zero.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_abs,
  input  logic [WIDTH-1:0] b_abs,
  output logic             step_done,
  output logic [WIDTH-1:0] hi_raw,
  output logic [WIDTH-1:0] lo_raw
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic             div_q;

  logic [WIDTH-1:0] hi_d, lo_d, addend_s, diff_s;
  logic [WIDTH:0]   sum_s, sh_s;
  logic             ge_s;

  // One multiply (shift-add, LSB first) or divide (restoring, MSB first) step.
  always_comb begin
    addend_s = lo_q[0] ? m_q : {WIDTH{1'b0}};
    sum_s    = {1'b0, hi_q} + {1'b0, addend_s};
    // Partial remainder shifted left with the next dividend bit brought in.
    sh_s     = {hi_q, lo_q[WIDTH-1]};
    ge_s     = (sh_s >= {1'b0, m_q});
    // When ge_s holds the difference is below the divisor, so WIDTH bits suffice.
    diff_s   = sh_s[WIDTH-1:0] - m_q;
    if (div_q) begin
      hi_d = ge_s ? diff_s : sh_s[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge_s};
    end else begin
      hi_d = sum_s[WIDTH:1];
      lo_d = {sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand capture, step counter and partial-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= {WIDTH{1'b0}};
      m_q   <= {WIDTH{1'b0}};
      div_q <= 1'b0;
    end else if (load) begin
      cnt_q <= CW'(WIDTH);
      hi_q  <= {WIDTH{1'b0}};
      lo_q  <= a_abs;
      m_q   <= b_abs;
      div_q <= is_div;
    end else if (cnt_q != {CW{1'b0}}) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign step_done = (cnt_q == CW'(1));
  assign hi_raw    = hi_q;
  assign lo_raw    = lo_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle MIPS integer execution unit with start/done handshake.
//   start/op/a/b   - request, accepted on an edge with start && !busy
//   result/zero    - registered result and its zero flag, held between dones
//   ovf            - signed overflow of ADD/SUB
//   div0           - divide by zero on DIV/DIVU
//   busy/done      - mul/div in flight / one-cycle completion pulse
//   hi/lo          - architectural HI/LO, written only when a mul/div finishes
// Single-cycle ops complete one cycle after accept; mul/div take WIDTH+2.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t       state_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, a_q;
  logic             zero_q, ovf_q, div0_q, busy_q, done_q;
  logic             q_neg_q, r_neg_q, is_div_q, b_zero_q;

  alu_op_t          op_s;
  logic             accept_s, load_s, is_div_s, a_neg_s, b_neg_s, sc_ovf_s, step_done_s;
  logic [WIDTH-1:0] add_s, sub_s, sc_result_s, a_abs_s, b_abs_s;
  logic [WIDTH-1:0] hi_raw_s, lo_raw_s, fix_hi_s, fix_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  assign op_s     = alu_op_t'(op);
  assign accept_s = start && (state_q == ST_IDLE);
  assign load_s   = accept_s && is_muldiv(op_s);
  assign is_div_s = (op_s == OP_DIV) || (op_s == OP_DIVU);

  // Single-cycle result and overflow for the op presented this cycle.
  always_comb begin
    add_s       = a + b;
    sub_s       = a - b;
    sc_result_s = {WIDTH{1'b0}};
    sc_ovf_s    = 1'b0;
    case (op_s)
      OP_ADD: begin
        sc_result_s = add_s;
        sc_ovf_s    = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result_s = sub_s;
        sc_ovf_s    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_result_s = a & b;
      OP_OR:   sc_result_s = a | b;
      OP_XOR:  sc_result_s = a ^ b;
      OP_NOR:  sc_result_s = ~(a | b);
      OP_SLT:  sc_result_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_result_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MFHI: sc_result_s = hi_q;
      OP_MFLO: sc_result_s = lo_q;
      default: sc_result_s = {WIDTH{1'b0}};
    endcase
  end

  // Magnitudes handed to the unsigned datapath; unsigned ops pass through.
  always_comb begin
    a_neg_s = is_signed(op_s) && a[WIDTH-1];
    b_neg_s = is_signed(op_s) && b[WIDTH-1];
    a_abs_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
    b_abs_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .is_div    (is_div_s),
    .a_abs     (a_abs_s),
    .b_abs     (b_abs_s),
    .step_done (step_done_s),
    .hi_raw    (hi_raw_s),
    .lo_raw    (lo_raw_s)
  );

  // Sign correction of the raw unsigned result. MIN / -1 needs no special
  // case: |MIN| / 1 = MIN, and negating MIN yields MIN again.
  always_comb begin
    prod_s     = {hi_raw_s, lo_raw_s};
    prod_fix_s = q_neg_q ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    if (is_div_q) begin
      if (b_zero_q) begin
        fix_hi_s = a_q;
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_hi_s = r_neg_q ? ({WIDTH{1'b0}} - hi_raw_s) : hi_raw_s;
        fix_lo_s = q_neg_q ? ({WIDTH{1'b0}} - lo_raw_s) : lo_raw_s;
      end
    end else begin
      fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Handshake FSM and all architectural output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_s) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            a_q      <= a;
            q_neg_q  <= a_neg_s ^ b_neg_s;
            r_neg_q  <= a_neg_s;
            is_div_q <= is_div_s;
            b_zero_q <= (b == {WIDTH{1'b0}});
          end else if (accept_s) begin
            result_q <= sc_result_s;
            zero_q   <= (sc_result_s == {WIDTH{1'b0}});
            ovf_q    <= sc_ovf_s;
            div0_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (step_done_s) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q     <= fix_hi_s;
          lo_q     <= fix_lo_s;
          result_q <= fix_lo_s;
          zero_q   <= (fix_lo_s == {WIDTH{1'b0}});
          ovf_q    <= 1'b0;
          div0_q   <= is_div_q && b_zero_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign div0   = div0_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu (WIDTH=32).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic [W-1:0]  result, hi, lo;
  logic          zero, ovf, div0, busy, done;

  int checks   = 0;
  int failures = 0;
  int lat, bc, pulses;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .ovf    (ovf),
    .div0   (div0),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single cycle; returns at the falling edge after accept.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally pulse an ADD request at cycle inj.
  task automatic wait_done(input int inj, output int latency, output int busy_cycles);
    latency = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && latency < 60) begin
      if (busy === 1'b1) busy_cycles++;
      if (latency == inj) begin
        start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      latency++;
    end
    start = 1'b0;
  endtask

  task automatic mdu(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_div0, input int inj);
    issue(o, x, y);
    wait_done(inj, lat, bc);
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, "_result"}, {32'd0, result}, {32'd0, exp_lo});
    check({tag, "_div0"}, {63'd0, div0}, {63'd0, exp_div0});
    check({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_div0", {63'd0, div0}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;

    // ADD overflow into the sign bit
    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_done", {63'd0, done}, 64'd1);
    check("add_busy", {63'd0, busy}, 64'd0);
    check("add_result", {32'd0, result}, 64'h8000_0000);
    check("add_ovf", {63'd0, ovf}, 64'd1);
    check("add_zero", {63'd0, zero}, 64'd0);
    @(negedge clk);
    check("add_done_pulse", {63'd0, done}, 64'd0);
    check("add_result_hold", {32'd0, result}, 64'h8000_0000);

    issue(4'd1, 32'd5, 32'd5);
    check("sub_result", {32'd0, result}, 64'd0);
    check("sub_zero", {63'd0, zero}, 64'd1);
    check("sub_ovf", {63'd0, ovf}, 64'd0);
    issue(4'd1, 32'h8000_0000, 32'd1);
    check("sub_ovf_neg", {63'd0, ovf}, 64'd1);
    check("sub_ovf_res", {32'd0, result}, 64'h7FFF_FFFF);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1);
    check("slt", {32'd0, result}, 64'd1);
    check("slt_ovf", {63'd0, ovf}, 64'd0);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    check("sltu", {32'd0, result}, 64'd0);
    issue(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("xor", {32'd0, result}, 64'hFF00_FF00);
    issue(4'd5, 32'h0000_0000, 32'h0000_0000);
    check("nor", {32'd0, result}, 64'hFFFF_FFFF);
    issue(4'd14, 32'h1234_5678, 32'h1111_1111);
    check("rsv14", {32'd0, result}, 64'd0);

    mdu("mult", 4'd10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
    // MFHI issued in the done cycle must see the new HI
    start = 1'b1; op = 4'd8;
    @(negedge clk);
    start = 1'b0;
    check("mfhi_done", {63'd0, done}, 64'd1);
    check("mfhi_result", {32'd0, result}, 64'hFFFF_FFFF);
    issue(4'd9, 32'd0, 32'd0);
    check("mflo_result", {32'd0, result}, 64'hFFFF_FFFA);

    mdu("multu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    mdu("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    mdu("divu_zero", 4'd13, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 0);
    issue(4'd0, 32'd1, 32'd2);
    check("div0_cleared", {63'd0, div0}, 64'd0);
    check("add_after_div", {32'd0, result}, 64'd3);
    mdu("div_min", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 0);
    // ADD request during RUN must be ignored
    mdu("div_ignore", 4'd12, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 5);

    // Reset at cycle 10 of a DIVU aborts it
    issue(4'd13, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    // Reset wins over a simultaneous start
    start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check("rst_start_done", {63'd0, done}, 64'd0);
    check("rst_start_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    check("rst_start_done2", {63'd0, done}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
